// File: rtl/instruction_cache_if.sv
// CPU fetch port and block-wide instruction memory port of the instruction cache.
// master = the cache itself, slave = the CPU/memory side that drives PC and read data.
interface instruction_cache_if #(
  parameter int ADDR_BITS = 10,
  parameter int LINE_BITS = 128
);
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 MEM_READ;
  logic [ADDR_BITS-5:0] MEM_ADDRESS;
  logic [LINE_BITS-1:0] MEM_READDATA;
  logic                 MEM_BUSYWAIT;

  modport master (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport slave (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, block refill on miss.
//   state      | meaning
//   IDLE       | lookup; hit serves the word, miss latches tag/index
//   MEM_READ   | MEM_READ held until memory drops MEM_BUSYWAIT, block captured
//   UPDATE     | captured block, tag and valid written into the latched line
module instruction_cache #(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_BITS       = 10
) (
  input logic                 CLK,
  input logic                 RESET,
  instruction_cache_if.master bus
);
  localparam int IW  = $clog2(NUM_BLOCKS);
  localparam int WSW = $clog2(WORDS_PER_BLOCK);
  localparam int OW  = WSW + 2;
  localparam int TW  = ADDR_BITS - OW - IW;
  localparam int LW  = 32 * WORDS_PER_BLOCK;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_READ = 2'd1;
  localparam logic [1:0] S_UPDATE   = 2'd2;

  logic [1:0]            state;
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TW-1:0]         tag_mem  [NUM_BLOCKS];
  logic [LW-1:0]         data_mem [NUM_BLOCKS];
  logic [IW-1:0]         idx_q;
  logic [TW-1:0]         tag_q;
  logic [LW-1:0]         fill_q;
  logic [31:0]           instr_q;

  logic [IW-1:0]         pc_idx;
  logic [TW-1:0]         pc_tag;
  logic [WSW-1:0]        pc_word;
  logic [WSW+4:0]        word_lsb;
  logic [31:0]           hit_word;
  logic                  hit;
  logic                  unused_pc;

  assign pc_word   = bus.PC[OW-1:2];
  assign pc_idx    = bus.PC[OW+IW-1:OW];
  assign pc_tag    = bus.PC[ADDR_BITS-1:OW+IW];
  assign unused_pc = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};

  assign word_lsb = {pc_word, 5'd0};
  assign hit_word = data_mem[pc_idx][word_lsb +: 32];
  assign hit      = (state == S_IDLE) && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  // RESET gates BUSYWAIT so the stall drops the instant reset is applied
  assign bus.BUSYWAIT    = RESET && !hit;
  assign bus.INSTRUCTION = hit ? hit_word : instr_q;
  assign bus.MEM_READ    = (state == S_MEM_READ);
  assign bus.MEM_ADDRESS = {tag_q, idx_q};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      valid_q <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      instr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            instr_q <= hit_word;
          end else begin
            idx_q <= pc_idx;
            tag_q <= pc_tag;
            state <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!bus.MEM_BUSYWAIT) state <= S_UPDATE;
        end
        S_UPDATE: begin
          valid_q[idx_q] <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid_q alone decides whether a line is usable
  always_ff @(posedge CLK) begin
    if (state == S_MEM_READ && !bus.MEM_BUSYWAIT) fill_q <= bus.MEM_READDATA;
    if (state == S_UPDATE) begin
      data_mem[idx_q] <= fill_q;
      tag_mem[idx_q]  <= tag_q;
    end
  end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU's PC output and a block-wide instruction memory.
- Takes the CPU's 32-bit PC. On a hit, returns the 32-bit INSTRUCTION in the same cycle.
- On a miss, raises BUSYWAIT to stall the CPU, fetches the 16-byte block from memory through a read/busywait handshake, installs it, then serves the word.
- The programme counter must hold its value while BUSYWAIT=1.

Parameters:
NUM_BLOCKS, 8, number of cache lines (power of 2); index width IW=log2(NUM_BLOCKS)=3
WORDS_PER_BLOCK, 4, 32-bit words per line; word-select width 2, line width 128 bits
ADDR_BITS, 10, PC bits used; PC[31:ADDR_BITS] ignored; tag width TW=ADDR_BITS-4-IW=3

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
PC  in  32  byte address of the instruction from the programme counter
INSTRUCTION  out  32  instruction word to the CPU decoder
BUSYWAIT  out  1  stall request to the CPU; high while the current PC is not served
MEM_READ  out  1  block read request to instruction memory
MEM_ADDRESS  out  ADDR_BITS-4 (6)  block address = latched PC[9:4]
MEM_READDATA  in  128  returned block; word 0 at [31:0], word 3 at [127:96]
MEM_BUSYWAIT  in  1  memory busy; must rise in the same cycle it sees MEM_READ=1

Behaviour:
Address split:
- PC[1:0] ignored (alignment).
- Word = PC[3:2], index = PC[6:4], tag = PC[9:7].
Storage:
- Per line: valid bit, TW-bit tag, 128-bit data.
- No dirty bits; the cache is never written by the CPU.
Reset (RESET=0, takes effect immediately, independent of CLK):
- All valid bits cleared; state goes to IDLE.
- MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=0.
- Tag and data contents need not be cleared.
Hit (combinational, IDLE only):
- Hit = valid[index] && tag[index]==PC tag.
- On hit, INSTRUCTION = data[index] word PC[3:2] and BUSYWAIT=0 in the same cycle; zero-cycle penalty.
FSM states IDLE, MEM_READ, UPDATE:
- IDLE:
  - On miss, BUSYWAIT=1 combinationally in the same cycle.
  - At the next posedge, latch index and tag, go to MEM_READ.
  - While RESET is deasserted, the line {PC[9:4]} is requested in MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS = latched {tag,index}, BUSYWAIT=1.
  - At a posedge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
  - Otherwise stay.
- UPDATE:
  - MEM_READ=0, BUSYWAIT=1.
  - At the posedge, write data, tag and valid=1 into the latched index, then go to IDLE.
  - The re-evaluated lookup then hits and BUSYWAIT falls.
Miss penalty:
- Cycles from the miss to BUSYWAIT=0 = 1 (IDLE->MEM_READ) + cycles spent in MEM_READ + 1 (UPDATE).
Boundary conditions:
- The fill always targets the latched address. A PC change during a fill (protocol violation) must not corrupt the latched line; it is re-looked-up in IDLE.
- Reset asserted mid-fill: abort immediately, MEM_READ drops, the line stays invalid.
- Conflict miss (same index, different tag): the old line is overwritten unconditionally.
- INSTRUCTION during a miss holds the last driven value; the CPU must ignore it while BUSYWAIT=1.

Test Plan:
- Reset and cold miss:
  - Hold RESET=0 -> BUSYWAIT=0, MEM_READ=0, INSTRUCTION=0.
  - Release RESET with PC=0 -> BUSYWAIT=1 that cycle; MEM_READ=1 and MEM_ADDRESS=6'h00 after the next posedge.
- Fill and word select:
  - Memory holds MEM_BUSYWAIT=1 for 5 cycles, then returns 128'h0000000C_00000008_00000004_00000000.
  - Required: one UPDATE cycle, then INSTRUCTION=32'h0 with BUSYWAIT=0.
  - PC=4, 8, 12 -> 32'h4, 32'h8, 32'hC, each hit with BUSYWAIT=0 and no MEM_READ.
- Conflict:
  - After block 0 is filled, PC=0x080 -> miss with MEM_ADDRESS=6'h08; the line is refilled.
  - Then PC=0x000 -> miss again with MEM_ADDRESS=6'h00.
- Ignored bits:
  - With block 0 valid, PC=32'h0000_0404 and PC=32'h0000_0002 -> both hit and return word 1 and word 0 respectively.
- Reset mid-fill:
  - Assert RESET=0 two cycles into MEM_READ -> MEM_READ=0 and BUSYWAIT=0 immediately without waiting for CLK.
  - After release, PC=0 misses again with MEM_READ reissued for address 6'h00.
